memoria_principal_ctrl: RTL
===========================

Name: memoria_principal_ctrl

Overview:
- Main-memory backing store and controller sitting directly downstream of memoriaCache.
- Services one cache transaction at a time: an optional write-back of a dirty victim line, then a refill read.
- Models a 32-word x 3-bit main memory with a fixed, parameterised access latency.
- Uses a req/busy/done handshake so the cache can stall on a miss.

Parameters:
- ADDR_W, 5, word address width; tag 3 bits + index 2 bits.
- DATA_W, 3, data word width.
- LATENCY, 4, clock cycles per memory access; legal range 1..15.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  transaction request from the cache; sampled only in IDLE.
- wb  in  1  with req, the transaction includes a write-back.
- rd_address  in  ADDR_W  refill read address; latched on acceptance.
- wb_address  in  ADDR_W  write-back address; latched on acceptance.
- wb_data  in  DATA_W  write-back data; latched on acceptance.
- busy  out  1  high while a transaction is in progress (WB or RD state).
- done  out  1  one-cycle pulse; rd_data is valid from this edge.
- rd_data  out  DATA_W  refill data; held until the next done.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE; busy=0, done=0, rd_data=0, counter=0.
  - Every memory word is initialised: mem[i] = i mod 8, i.e. the low 3 bits of the address.
- FSM states: IDLE, WB, RD, DONE.
  - IDLE: when req=1 at edge E0, latch rd_address, wb, wb_address and wb_data. Go to WB if wb=1, else RD. Load the counter with LATENCY-1. busy rises at E0.
  - WB: decrement the counter each edge. At the edge where the counter is 0, write mem[wb_address]=wb_data, reload the counter with LATENCY-1, and go to RD.
  - RD: decrement the counter each edge. At the edge where the counter is 0, set rd_data=mem[rd_address], done=1, busy=0, and go to DONE.
  - DONE: lasts exactly one cycle; req is ignored; done falls at the next edge; return to IDLE.
- Latency:
  - Without write-back: done rises at edge E0+LATENCY.
  - With write-back: done rises at edge E0+2*LATENCY.
  - busy is high for LATENCY or 2*LATENCY cycles respectively.
- Handshake:
  - The requester holds req and its operands until it sees done, and drops req during the DONE cycle.
  - If req is still high in IDLE after DONE, it is accepted as a new transaction.
  - Inputs that change while busy are ignored; the latched copies are used.
- Ordering: the write-back always completes before the refill read. If wb_address==rd_address, rd_data returns the newly written data.
- Reset asserted mid-transaction: abort immediately, no done pulse, memory re-initialised.
- LATENCY=1: WB and RD each last one cycle. The counter width is 4 bits.

Optional Feature:
- Macro: MEM_STATS_EN.
- With the macro defined, two extra outputs are present:
  - rd_count[7:0]: increments at each done.
  - wb_count[7:0]: increments at each WB memory write.
  - Both counters saturate at 255 and are cleared by reset.
- Without the macro, these ports and their logic do not exist. Core timing is identical in both builds.

Decomposition:
- Shared package memoria_pkg holds:
  - ADDR_W, DATA_W, TAG_W=3, INDEX_W=2.
  - The FSM state enum (IDLE, WB, RD, DONE).
  - The reset-initialisation function for word i (returns i mod 8).
- Sub-module latency_counter:
  - Loadable 4-bit down-counter with a zero flag.
  - Instantiated once and shared by the WB and RD states.

Test Plan:
- Read, no write-back: reset, then req=1, wb=0, rd_address=10000 → busy high for 4 cycles; done pulses at E0+4; rd_data=0.
- Write-back then read: req=1, wb=1, wb_address=00001, wb_data=101, rd_address=01001 → done at E0+8; rd_data=001. A following read of 00001 returns 101.
- Same address for write-back and read: wb=1, wb_address=01101, wb_data=001, rd_address=01101 → rd_data=001, not the initial value 101.
- Handshake:
  - req held high through DONE → ignored in DONE, re-accepted in IDLE one cycle later.
  - Operand changes while busy → no effect on rd_data.
- Reset mid-transaction: reset at E0+2 during WB → busy=0 and done=0 immediately; a later read of wb_address returns its initial value.
- Stats (MEM_STATS_EN defined): 3 reads, one of them with write-back → rd_count=3, wb_count=1. Forcing 300 reads → rd_count=255.

Source files
------------

// File: rtl/memoria_pkg.sv
// Shared definitions for the main-memory controller: widths,
// FSM state encoding and the power-on contents of each word.
package memoria_pkg;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 3;
  localparam int TAG_W   = 3;
  localparam int INDEX_W = 2;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_e;

  // Word i comes out of reset holding the low bits of its address.
  function automatic logic [DATA_W-1:0] init_word(input int i);
    return DATA_W'(i % 8);
  endfunction

endpackage

// File: rtl/memoria_principal_ctrl_latency_counter.sv
// Loadable 4-bit down-counter with a zero flag.
// Ports: clock, reset, load_i/load_val_i, dec_i, zero_o.
module latency_counter
  import memoria_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/memoria_principal_ctrl.sv
// Main-memory store + controller behind memoriaCache: optional
// write-back then refill read, req/busy/done handshake.
// Ports: clock, reset, req, wb, rd_address, wb_address, wb_data,
// busy, done, rd_data; rd_count/wb_count when MEM_STATS_EN is defined.
module memoria_principal_ctrl
  import memoria_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              wb,
  input  logic [ADDR_W-1:0] rd_address,
  input  logic [ADDR_W-1:0] wb_address,
  input  logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              done,
`ifdef MEM_STATS_EN
  output logic [7:0]        rd_count,
  output logic [7:0]        wb_count,
`endif
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(LATENCY - 1);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic latch;
  logic load;
  logic dec;
  logic cnt_zero;
  logic mem_we;
  logic rd_we;

  latency_counter u_cnt (
    .clock      (clock),
    .reset      (reset),
    .load_i     (load),
    .load_val_i (RELOAD),
    .dec_i      (dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    load    = 1'b0;
    dec     = 1'b0;
    mem_we  = 1'b0;
    rd_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          latch   = 1'b1;
          load    = 1'b1;
          state_d = wb ? WB : RD;
        end
      end
      WB: begin
        if (cnt_zero) begin
          mem_we  = 1'b1;
          load    = 1'b1;
          state_d = RD;
        end else begin
          dec = 1'b1;
        end
      end
      RD: begin
        if (cnt_zero) begin
          rd_we   = 1'b1;
          state_d = DONE;
        end else begin
          dec = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        rd_addr_q <= rd_address;
        wb_addr_q <= wb_address;
        wb_data_q <= wb_data;
      end
      if (rd_we) rd_data_q <= mem_q[rd_addr_q];
    end
  end

  // The write-back lands one edge or more before the refill read,
  // so a same-address refill sees the new data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= init_word(i);
      end
    end else if (mem_we) begin
      mem_q[wb_addr_q] <= wb_data_q;
    end
  end

`ifdef MEM_STATS_EN
  logic [7:0] rd_cnt_q;
  logic [7:0] wb_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wb_cnt_q <= '0;
    end else begin
      if (rd_we && rd_cnt_q != 8'hFF) rd_cnt_q <= rd_cnt_q + 8'd1;
      if (mem_we && wb_cnt_q != 8'hFF) wb_cnt_q <= wb_cnt_q + 8'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wb_count = wb_cnt_q;
`endif

  assign busy    = (state_q == WB) || (state_q == RD);
  assign done    = (state_q == DONE);
  assign rd_data = rd_data_q;

endmodule
